// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: pops one byte per frame from the TX FIFO and serializes it
// LSB first as an 8N1 frame, or 8E1 when PARITY_EN is set.
module uart_tx_controller #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       enable,
  input  logic       tx_fifo_Empty,
  input  logic [7:0] tx_fifo_dataOut,
  output logic       tx_fifo_readEn,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StFetch,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_q, rd_d;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;

    case (state_q)
      StIdle: begin
        if (enable && !tx_fifo_Empty) state_d = StRead;
      end
      StRead: state_d = StFetch;
      StFetch: begin
        // Parity comes from this snapshot, since the shift register is consumed bit by bit
        shift_d = tx_fifo_dataOut;
        par_d   = ^tx_fifo_dataOut;
        idx_d   = 3'd0;
        state_d = StStart;
      end
      StStart: begin
        if (cnt_last) state_d = StData;
      end
      StData: begin
        if (cnt_last) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        if (cnt_last) state_d = StStop;
      end
      StStop: begin
        if (cnt_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q inside {StStart, StData, StParity, StStop}) begin
      cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are registered images of the next state so they line up with state_q
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StStop) && (cnt_d == CntMax);
    rd_d   = (state_d == StRead);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
    end
  end

  assign tx             = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign tx_fifo_readEn = rd_q;

endmodule
